// File: rtl/bcd_seg_pkg.sv
// rtl/bcd_seg_pkg.sv - segment patterns and default sizing for the BCD scan display
package bcd_seg_pkg;

  localparam int DEF_NDIG = 4;
  localparam int DEF_DIV  = 50000;

  // Active-high {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd7_dec.sv
// rtl/bcd7_dec.sv - combinational BCD nibble to active-high 7-segment decoder
module bcd7_dec
  import bcd_seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Non-decimal nibbles render as a dash so a bad converter output is visible
  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// rtl/bcd_seg_scan.sv - time-multiplexed common-anode 7-segment scanner for latched BCD digits
module bcd_seg_scan
  import bcd_seg_pkg::*;
#(
  parameter int NDIG        = DEF_NDIG,
  parameter int DIV         = DEF_DIV,
  parameter int SEG_ACT_LOW = 1,
  parameter int AN_ACT_LOW  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic [4*NDIG-1:0] dat,
  input  logic [NDIG-1:0]   dp,
  input  logic              blank_en,
  output logic [6:0]        seg,
  output logic              seg_dp,
  output logic [NDIG-1:0]   an,
  output logic              tick,
  output logic              err
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [6:0]      SEG_INV = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic            DP_INV  = (SEG_ACT_LOW != 0);
  localparam logic [NDIG-1:0] AN_INV  = (AN_ACT_LOW != 0) ? {NDIG{1'b1}} : {NDIG{1'b0}};

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [4*NDIG-1:0] sh_dat_q, sh_dat_d;
  logic [NDIG-1:0]   sh_dp_q, sh_dp_d;
  logic [6:0]        seg_q, seg_d;
  logic              seg_dp_q, seg_dp_d;
  logic [NDIG-1:0]   an_q, an_d;
  logic              tick_q, tick_d;
  logic              err_q, err_d;

  logic              wrap;
  logic [3:0]        digit;
  logic [6:0]        dec_seg;
  logic              zero_above;
  logic              blank_cur;
  logic              dp_cur;
  logic [NDIG-1:0]   onehot;

  bcd7_dec u_dec (
    .bcd_i (digit),
    .seg_o (dec_seg)
  );

  assign wrap = (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d      = wrap ? '0 : cnt_q + 1'b1;
    tick_d     = (cnt_d == CW'(DIV - 1));
    idx_d      = idx_q;
    if (wrap) begin
      idx_d = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
    end
    sh_dat_d   = ld ? dat : sh_dat_q;
    sh_dp_d    = ld ? dp : sh_dp_q;

    // Walk from the MSD down so zero_above covers digits NDIG-1..i at step i
    digit      = 4'h0;
    zero_above = 1'b1;
    blank_cur  = 1'b0;
    dp_cur     = 1'b0;
    err_d      = 1'b0;
    onehot     = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      zero_above = zero_above && (sh_dat_q[4*i +: 4] == 4'h0);
      onehot[i]  = (idx_d == IW'(i));
      if (idx_d == IW'(i)) begin
        digit     = sh_dat_q[4*i +: 4];
        dp_cur    = sh_dp_q[i];
        blank_cur = blank_en && (i != 0) && zero_above;
      end
      if (sh_dat_q[4*i +: 4] > 4'd9) begin
        err_d = 1'b1;
      end
    end

    seg_d    = seg_q;
    seg_dp_d = seg_dp_q;
    an_d     = an_q;
    if (wrap) begin
      seg_d    = (blank_cur ? SEG_OFF : dec_seg) ^ SEG_INV;
      seg_dp_d = dp_cur ^ DP_INV;
      an_d     = onehot ^ AN_INV;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      sh_dat_q <= '0;
      sh_dp_q  <= '0;
      seg_q    <= SEG_OFF ^ SEG_INV;
      seg_dp_q <= DP_INV;
      an_q     <= AN_INV;
      tick_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sh_dat_q <= sh_dat_d;
      sh_dp_q  <= sh_dp_d;
      seg_q    <= seg_d;
      seg_dp_q <= seg_dp_d;
      an_q     <= an_d;
      tick_q   <= tick_d;
      err_q    <= err_d;
    end
  end

  assign seg    = seg_q;
  assign seg_dp = seg_dp_q;
  assign an     = an_q;
  assign tick   = tick_q;
  assign err    = err_q;

endmodule
